// File: rtl/huffman_lookup_rom.sv
// Fixed canonical Huffman table: 7-bit ASCII to right-aligned code word and length.
// Optional miss counter is built only when HUFF_MISS_STATS_EN is defined.
module huffman_lookup_rom (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  ascii,
    input  logic        lookup,
    output logic [9:0]  huffman_code,
    output logic [3:0]  bit_length,
    output logic        unmapped,
    output logic [9:0]  code_q,
    output logic [3:0]  length_q,
    output logic [15:0] miss_count
);

    // Table lookup; anything not listed decodes to an empty code of length 0.
    always_comb begin
        huffman_code = 10'd0;
        bit_length   = 4'd0;
        case (ascii)
            7'h20: begin huffman_code = 10'b000;        bit_length = 4'd3;  end
            7'h61: begin huffman_code = 10'b001;        bit_length = 4'd3;  end
            7'h65: begin huffman_code = 10'b010;        bit_length = 4'd3;  end
            7'h74: begin huffman_code = 10'b011;        bit_length = 4'd3;  end
            7'h68: begin huffman_code = 10'b1000;       bit_length = 4'd4;  end
            7'h69: begin huffman_code = 10'b1001;       bit_length = 4'd4;  end
            7'h6e: begin huffman_code = 10'b1010;       bit_length = 4'd4;  end
            7'h6f: begin huffman_code = 10'b1011;       bit_length = 4'd4;  end
            7'h72: begin huffman_code = 10'b1100;       bit_length = 4'd4;  end
            7'h73: begin huffman_code = 10'b1101;       bit_length = 4'd4;  end
            7'h64: begin huffman_code = 10'b11100;      bit_length = 4'd5;  end
            7'h6c: begin huffman_code = 10'b11101;      bit_length = 4'd5;  end
            7'h63: begin huffman_code = 10'b111100;     bit_length = 4'd6;  end
            7'h6d: begin huffman_code = 10'b111101;     bit_length = 4'd6;  end
            7'h75: begin huffman_code = 10'b111110;     bit_length = 4'd6;  end
            7'h77: begin huffman_code = 10'b1111110;    bit_length = 4'd7;  end
            7'h66: begin huffman_code = 10'b11111110;   bit_length = 4'd8;  end
            7'h67: begin huffman_code = 10'b111111110;  bit_length = 4'd9;  end
            7'h70: begin huffman_code = 10'b1111111110; bit_length = 4'd10; end
            7'h79: begin huffman_code = 10'b1111111111; bit_length = 4'd10; end
            default: begin
                huffman_code = 10'd0;
                bit_length   = 4'd0;
            end
        endcase
    end

    // Every table entry has a nonzero length, so length 0 marks a miss.
    assign unmapped = (bit_length == 4'd0);

    // Capture stage: load on lookup, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q   <= 10'd0;
            length_q <= 4'd0;
        end else if (lookup) begin
            code_q   <= huffman_code;
            length_q <= bit_length;
        end
    end

`ifdef HUFF_MISS_STATS_EN
    logic [15:0] miss_q;

    // Saturating count of captured lookups that hit no table entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_q <= 16'd0;
        end else if (lookup && unmapped && (miss_q != 16'hFFFF)) begin
            miss_q <= miss_q + 16'd1;
        end
    end

    assign miss_count = miss_q;
`else
    assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_huffman_lookup_rom.sv
// Self-checking bench for huffman_lookup_rom against a canonical-code model
// built from the symbol/length list.
module tb_huffman_lookup_rom;

    logic        clk;
    logic        reset;
    logic [6:0]  ascii;
    logic        lookup;
    logic [9:0]  huffman_code;
    logic [3:0]  bit_length;
    logic        unmapped;
    logic [9:0]  code_q;
    logic [3:0]  length_q;
    logic [15:0] miss_count;

    huffman_lookup_rom dut (
        .clk          (clk),
        .reset        (reset),
        .ascii        (ascii),
        .lookup       (lookup),
        .huffman_code (huffman_code),
        .bit_length   (bit_length),
        .unmapped     (unmapped),
        .code_q       (code_q),
        .length_q     (length_q),
        .miss_count   (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    byte unsigned syms [20] = '{8'h20, 8'h61, 8'h65, 8'h74,
                                8'h68, 8'h69, 8'h6e, 8'h6f, 8'h72, 8'h73,
                                8'h64, 8'h6c, 8'h63, 8'h6d, 8'h75,
                                8'h77, 8'h66, 8'h67, 8'h70, 8'h79};
    int lens [20] = '{3, 3, 3, 3, 4, 4, 4, 4, 4, 4,
                      5, 5, 6, 6, 6, 7, 8, 9, 10, 10};

    logic [9:0] mcode [128];
    int         mlen  [128];
    logic [9:0] dcode [128];
    int         dlen  [128];

    logic [9:0]  exp_cq;
    logic [3:0]  exp_lq;
    logic [15:0] exp_miss;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Canonical assignment: consecutive codes, left-shifted when length grows.
    task automatic build_model();
        int code;
        for (int a = 0; a < 128; a++) begin
            mcode[a] = 10'd0;
            mlen[a]  = 0;
        end
        code = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) code = (code + 1) << (lens[i] - lens[i-1]);
            mcode[syms[i][6:0]] = code[9:0];
            mlen[syms[i][6:0]]  = lens[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (lookup) begin
            exp_cq = mcode[ascii];
            exp_lq = 4'(mlen[ascii]);
`ifdef HUFF_MISS_STATS_EN
            if (mlen[ascii] == 0 && exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
`endif
        end
        #1;
    endtask

    task automatic check_comb(input string tag);
        check({tag, "_code"}, 16'(huffman_code), 16'(mcode[ascii]));
        check({tag, "_len"},  16'(bit_length),   16'(mlen[ascii]));
        check({tag, "_unm"},  16'(unmapped),     16'(mlen[ascii] == 0));
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_code_q"}, 16'(code_q),   16'(exp_cq));
        check({tag, "_len_q"},  16'(length_q), 16'(exp_lq));
        check({tag, "_miss"},   miss_count,    exp_miss);
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        exp_cq = 10'd0;
        exp_lq = 4'd0;
        exp_miss = 16'd0;
        #1;
        check_regs("async_rst");
        check_comb("rst_comb");
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int mapped;
        int bad;
        build_model();
        reset = 1'b1;
        ascii = 7'h00;
        lookup = 1'b0;
        exp_cq = 10'd0;
        exp_lq = 4'd0;
        exp_miss = 16'd0;
        #2;
        check_regs("reset");
        #10;
        reset = 1'b0;

        // Exhaustive combinational sweep.
        mapped = 0;
        for (int a = 0; a < 128; a++) begin
            ascii = 7'(a);
            #1;
            check_comb("sweep");
            dcode[a] = huffman_code;
            dlen[a]  = int'(bit_length);
            if (!unmapped) mapped++;
        end
        check("mapped_cnt", 16'(mapped), 16'd20);
        bad = 0;
        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 128; j++)
                if (i != j && dlen[i] > 0 && dlen[j] > 0 && dlen[i] <= dlen[j])
                    if ((dcode[j] >> (dlen[j] - dlen[i])) == dcode[i]) bad++;
        check("prefix_free", 16'(bad), 16'd0);

        // Spot values.
        ascii = 7'h20; #1;
        check("sp_code", 16'(huffman_code), 16'h000);
        check("sp_len", 16'(bit_length), 16'd3);
        ascii = 7'h79; #1;
        check("y_code", 16'(huffman_code), 16'h3FF);
        check("y_len", 16'(bit_length), 16'd10);
        ascii = 7'h68; #1;
        check("h_code", 16'(huffman_code), 16'h008);
        check("h_len", 16'(bit_length), 16'd4);
        ascii = 7'h41; #1;
        check("A_code", 16'(huffman_code), 16'h000);
        check("A_len", 16'(bit_length), 16'd0);
        check("A_unm", 16'(unmapped), 16'd1);

        // Capture and hold.
        tick();
        ascii = 7'h65;
        lookup = 1'b1;
        tick();
        lookup = 1'b0;
        check("e_code_q", 16'(code_q), 16'h002);
        check("e_len_q", 16'(length_q), 16'd3);
        ascii = 7'h67;
        tick();
        tick();
        check("hold_code_q", 16'(code_q), 16'h002);
        check("hold_len_q", 16'(length_q), 16'd3);
        check_regs("hold");

        // Reset between edges after a capture.
        async_reset();
        tick();
        check_regs("post_rst");

        // Miss counting: three misses and two hits.
        ascii = 7'h5A;
        lookup = 1'b1;
        repeat (3) tick();
        ascii = 7'h61;
        repeat (2) tick();
        lookup = 1'b0;
        tick();
`ifdef HUFF_MISS_STATS_EN
        check("miss_3", miss_count, 16'd3);
`else
        check("miss_off", miss_count, 16'd0);
`endif
        check_regs("miss_seq");

        // Randomized traffic with occasional mid-cycle reset.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 1) == 1)
                ascii = syms[$urandom_range(0, 19)][6:0];
            else
                ascii = 7'($urandom_range(0, 127));
            lookup = ($urandom_range(0, 3) != 0);
            #1;
            check_comb("rnd");
            tick();
            check_regs("rnd");
            if (k % 97 == 50) async_reset();
        end

`ifdef HUFF_MISS_STATS_EN
        // Drive the counter to saturation and past it.
        async_reset();
        ascii = 7'h5A;
        lookup = 1'b1;
        repeat (65535) tick();
        check("sat_ffff", miss_count, 16'hFFFF);
        repeat (2) tick();
        check("sat_hold", miss_count, 16'hFFFF);
        lookup = 1'b0;
        tick();
        check_regs("sat");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/huffman_lookup_rom.md
Name: huffman_lookup_rom

Overview:
- Fixed canonical Huffman code table mapping a 7-bit ASCII character to a code word (up to 10 bits) and its length.
- Combinational lookup feeds the huffman coder FSM, which latches code and length one cycle after accepting a character.
- A registered capture stage and an unmapped-symbol flag are provided for downstream pipelining and error checking.

Parameters:
- None. The table contents are fixed.

Ports:
- clk  input  1  system clock; all registers are rising-edge triggered.
- reset  input  1  asynchronous, active-high reset.
- ascii  input  7  character to look up.
- lookup  input  1  capture strobe for the registered outputs.
- huffman_code  output  10  combinational code word, right-aligned, upper unused bits 0.
- bit_length  output  4  combinational code length, 0 when unmapped.
- unmapped  output  1  combinational; 1 when ascii has no table entry.
- code_q  output  10  registered copy of huffman_code.
- length_q  output  4  registered copy of bit_length.
- miss_count  output  16  count of unmapped lookups; tied to 0 unless HUFF_MISS_STATS_EN is defined.

Behaviour:
- Alignment: the code occupies huffman_code[bit_length-1:0]. The first-transmitted (MSB) bit is bit[bit_length-1]. Bits above that are 0.
- Table: canonical code, complete (Kraft sum = 1). Characters are listed as ascii hex, then code bits.
  - len 3: 0x20 ' ' 000; 'a' 001; 'e' 010; 't' 011.
  - len 4: 'h' 1000; 'i' 1001; 'n' 1010; 'o' 1011; 'r' 1100; 's' 1101.
  - len 5: 'd' 11100; 'l' 11101.
  - len 6: 'c' 111100; 'm' 111101; 'u' 111110.
  - len 7: 'w' 1111110.
  - len 8: 'f' 11111110.
  - len 9: 'g' 111111110.
  - len 10: 'p' 1111111110; 'y' 1111111111.
- Unmapped characters (the other 108 values, including uppercase, digits and control codes): huffman_code=0, bit_length=0, unmapped=1.
- Mapped characters: unmapped=0. bit_length is always 0 or in 3..10.
- Combinational path: zero latency, purely a function of ascii. No dependency on clk, reset or lookup.
- Registered path:
  - On a rising clk edge with lookup=1, code_q and length_q load the current huffman_code and bit_length.
  - With lookup=0 they hold their value.
  - Capture latency is 1 cycle.
- Reset: code_q=0, length_q=0, miss_count=0, asserted asynchronously. Reset mid-operation clears the registers immediately. The combinational outputs are unaffected by reset.
- No X propagation: every ascii value yields defined outputs through a full case with default.

Optional Feature:
- Macro HUFF_MISS_STATS_EN.
- Defined:
  - miss_count is a 16-bit register that increments on each rising clk with lookup=1 and unmapped=1.
  - It saturates at 0xFFFF and does not wrap.
  - It is cleared by reset.
- Undefined: miss_count is constant 0 and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Exhaustive sweep ascii 0x00..0x7F: outputs equal the table above. 20 characters are mapped, 108 unmapped. Every mapped entry has a nonzero length, and no code is a prefix of another.
- ascii=0x20 -> huffman_code=0x000, bit_length=3. ascii='y' (0x79) -> 0x3FF, length 10. ascii='h' -> 0x008, length 4. ascii='A' (0x41) -> 0x000, length 0, unmapped=1.
- Set ascii='e', pulse lookup for 1 cycle -> next edge code_q=0x002, length_q=3. Change ascii to 'g' with lookup=0 -> code_q/length_q hold 0x002/3.
- Assert reset asynchronously between clock edges after a capture -> code_q=0, length_q=0 (and miss_count=0) immediately. Combinational outputs still track ascii.
- With HUFF_MISS_STATS_EN: 3 lookups of 'Z' plus 2 of 'a' -> miss_count=3. Force 0xFFFF + 1 miss -> stays 0xFFFF. Without the macro -> miss_count=0 throughout.
